// File: rtl/class_arbiter.sv
// Two-class weighted round-robin arbiter: pops two FIFOs by per-class credit
// and forwards each popped word with a two-cycle read-to-valid latency.
module class_arbiter #(
  parameter int DATA_SIZE = 10,
  parameter int WEIGHT0   = 3,
  parameter int WEIGHT1   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] fifo0_data,
  input  logic                 fifo0_empty,
  input  logic [DATA_SIZE-1:0] fifo1_data,
  input  logic                 fifo1_empty,
  input  logic                 dest_pause,
  output logic                 read0,
  output logic                 read1,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 valid_out,
  output logic                 class_out,
  output logic [7:0]           cnt0,
  output logic [7:0]           cnt1
);

  typedef enum logic [1:0] {IDLE, SERVE0, SERVE1} state_t;

  localparam logic [3:0] W0 = 4'(WEIGHT0);
  localparam logic [3:0] W1 = 4'(WEIGHT1);

  state_t     state, state_nxt;
  logic [3:0] credit, credit_nxt;
  logic       last, last_nxt;
  logic       rd_vld, rd_cls;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    read0      = (state == SERVE0) && !fifo0_empty && !dest_pause;
    read1      = (state == SERVE1) && !fifo1_empty && !dest_pause;
    state_nxt  = state;
    credit_nxt = credit;
    last_nxt   = last;

    if (!dest_pause) begin
      case (state)
        IDLE: begin
          if (!fifo0_empty || !fifo1_empty) begin
            // Prefer the class opposite the last one served.
            if (fifo1_empty || (!fifo0_empty && last)) begin
              state_nxt  = SERVE0;
              credit_nxt = W0;
            end else begin
              state_nxt  = SERVE1;
              credit_nxt = W1;
            end
          end
        end
        SERVE0: begin
          if (read0) begin
            last_nxt = 1'b0;
            if (credit == 4'd1) begin
              if (!fifo1_empty) begin
                state_nxt  = SERVE1;
                credit_nxt = W1;
              end else begin
                credit_nxt = W0;
              end
            end else begin
              credit_nxt = credit - 4'd1;
            end
          end else if (!fifo1_empty) begin
            state_nxt  = SERVE1;
            credit_nxt = W1;
          end else begin
            state_nxt = IDLE;
          end
        end
        SERVE1: begin
          if (read1) begin
            last_nxt = 1'b1;
            if (credit == 4'd1) begin
              if (!fifo0_empty) begin
                state_nxt  = SERVE0;
                credit_nxt = W0;
              end else begin
                credit_nxt = W1;
              end
            end else begin
              credit_nxt = credit - 4'd1;
            end
          end else if (!fifo0_empty) begin
            state_nxt  = SERVE0;
            credit_nxt = W0;
          end else begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      credit <= 4'd0;
      last   <= 1'b1;
    end else begin
      state  <= state_nxt;
      credit <= credit_nxt;
      last   <= last_nxt;
    end
  end

  // The popped word appears on the FIFO bus one cycle after the read strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_vld    <= 1'b0;
      rd_cls    <= 1'b0;
      data_out  <= '0;
      valid_out <= 1'b0;
      class_out <= 1'b0;
      cnt0      <= 8'd0;
      cnt1      <= 8'd0;
    end else begin
      rd_vld    <= read0 | read1;
      rd_cls    <= read1;
      valid_out <= rd_vld;
      if (rd_vld) begin
        data_out  <= rd_cls ? fifo1_data : fifo0_data;
        class_out <= rd_cls;
        if (rd_cls) cnt1 <= cnt1 + 8'd1;
        else        cnt0 <= cnt0 + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_class_arbiter.sv
// Self-checking bench for class_arbiter: behavioural FIFOs feed the DUT and a
// scoreboard of expected words is compared against each valid_out.
module tb_class_arbiter;

  typedef struct packed {
    logic       cls;
    logic [9:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] fifo0_data = '0;
  logic [9:0] fifo1_data = '0;
  logic       fifo0_empty = 1'b1;
  logic       fifo1_empty = 1'b1;
  logic       dest_pause = 1'b0;
  logic       read0, read1, valid_out, class_out;
  logic [9:0] data_out;
  logic [7:0] cnt0, cnt1;

  logic [9:0] q0[$];
  logic [9:0] q1[$];
  exp_t       exp_q[$];
  logic [7:0] exp_cnt0 = 8'd0;
  logic [7:0] exp_cnt1 = 8'd0;
  int         errors = 0;
  int         checks = 0;

  class_arbiter #(.DATA_SIZE(10), .WEIGHT0(3), .WEIGHT1(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo0_data (fifo0_data),
    .fifo0_empty(fifo0_empty),
    .fifo1_data (fifo1_data),
    .fifo1_empty(fifo1_empty),
    .dest_pause (dest_pause),
    .read0      (read0),
    .read1      (read1),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .class_out  (class_out),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] mk(input logic cls, input int n);
    return {cls, n[8:0]};
  endfunction

  // FIFO model: a strobe seen at an edge pops the head onto the data bus,
  // which then stays valid for the following cycle.
  always @(posedge clk) begin
    logic s0, s1;
    s0 = read0;
    s1 = read1;
    #1;
    if (s0 && q0.size() > 0) fifo0_data = q0.pop_front();
    if (s1 && q1.size() > 0) fifo1_data = q1.pop_front();
    fifo0_empty = (q0.size() == 0);
    fifo1_empty = (q1.size() == 0);
  end

  // Output monitor / scoreboard.
  always begin
    @(negedge clk);
    #2;
    if (!reset) begin
      exp_cnt0 = 8'd0;
      exp_cnt1 = 8'd0;
    end else begin
      checks++;
      if ((read0 && fifo0_empty) || (read1 && fifo1_empty) || (read0 && read1)) begin
        errors++;
        $display("FAIL read_guard: read0=%b read1=%b empty0=%b empty1=%b", read0, read1,
                 fifo0_empty, fifo1_empty);
      end
      if (valid_out) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: data_out=%0h class_out=%b", data_out, class_out);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.cls) exp_cnt1 = exp_cnt1 + 8'd1;
          else       exp_cnt0 = exp_cnt0 + 8'd1;
          if (data_out !== e.data || class_out !== e.cls) begin
            errors++;
            $display("FAIL word: got data=%0h class=%b expected data=%0h class=%b",
                     data_out, class_out, e.data, e.cls);
          end
          checks++;
          if (cnt0 !== exp_cnt0 || cnt1 !== exp_cnt1) begin
            errors++;
            $display("FAIL counters: got cnt0=%0d cnt1=%0d expected cnt0=%0d cnt1=%0d",
                     cnt0, cnt1, exp_cnt0, exp_cnt1);
          end
        end
      end
    end
  end

  task automatic load(input logic cls, input int n);
    for (int i = 0; i < n; i++) begin
      if (cls) q1.push_back(mk(1'b1, i));
      else     q0.push_back(mk(1'b0, i));
    end
    fifo0_empty = (q0.size() == 0);
    fifo1_empty = (q1.size() == 0);
  endtask

  task automatic expect_word(input logic cls, input int first, input int last_n);
    exp_t e;
    for (int i = first; i <= last_n; i++) begin
      e.cls  = cls;
      e.data = mk(cls, i);
      exp_q.push_back(e);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    dest_pause = 1'b0;
    q0.delete();
    q1.delete();
    exp_q.delete();
    fifo0_empty = 1'b1;
    fifo1_empty = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || q0.size() != 0 || q1.size() != 0) && n < 2000) begin
      @(negedge clk);
      #3;
      n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL %s_drain: %0d words still expected after %0d cycles", name,
               exp_q.size(), n);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({valid_out, class_out, data_out, cnt0, cnt1, read0, read1} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b class=%b data=%0h cnt0=%0d cnt1=%0d rd=%b%b",
               valid_out, class_out, data_out, cnt0, cnt1, read0, read1);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (read0 !== 1'b0 || read1 !== 1'b0 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL idle_quiet: rd=%b%b valid=%b expected 000", read0, read1, valid_out);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    load(1'b0, 8);
    load(1'b1, 8);
    expect_word(1'b0, 0, 2); expect_word(1'b1, 0, 0);
    expect_word(1'b0, 3, 5); expect_word(1'b1, 1, 1);
    expect_word(1'b0, 6, 7); expect_word(1'b1, 2, 7);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (valid_out !== (c >= 3)) begin
        errors++;
        $display("FAIL rr_valid_c%0d: got %b expected %b", c, valid_out, c >= 3);
      end
    end
    checks++;
    if (cnt0 !== 8'd6 || cnt1 !== 8'd2) begin
      errors++;
      $display("FAIL rr_counts: got cnt0=%0d cnt1=%0d expected 6 2", cnt0, cnt1);
    end
    wait_drain("rr");
  endtask

  task automatic test_class1_only();
    do_reset();
    load(1'b1, 4);
    expect_word(1'b1, 0, 3);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (read1 !== (c <= 4) || read0 !== 1'b0) begin
        errors++;
        $display("FAIL c1_read_c%0d: got read1=%b read0=%b expected %b 0", c, read1, read0,
                 c <= 4);
      end
    end
    wait_drain("c1");
    checks++;
    if (cnt1 !== 8'd4 || cnt0 !== 8'd0 || read1 !== 1'b0) begin
      errors++;
      $display("FAIL c1_final: got cnt1=%0d cnt0=%0d read1=%b expected 4 0 0", cnt1, cnt0,
               read1);
    end
  endtask

  task automatic test_pause();
    do_reset();
    load(1'b0, 8);
    load(1'b1, 4);
    expect_word(1'b0, 0, 2); expect_word(1'b1, 0, 0);
    expect_word(1'b0, 3, 5); expect_word(1'b1, 1, 1);
    expect_word(1'b0, 6, 7); expect_word(1'b1, 2, 3);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 3) dest_pause = 1'b1;
      if (c == 6) dest_pause = 1'b0;
      #1;
      if (c >= 3 && c <= 5) begin
        checks++;
        if (read0 !== 1'b0 || read1 !== 1'b0) begin
          errors++;
          $display("FAIL pause_read_c%0d: got rd=%b%b expected 00", c, read0, read1);
        end
      end
      if (c >= 4) begin
        checks++;
        if (valid_out !== (c == 4)) begin
          errors++;
          $display("FAIL pause_valid_c%0d: got %b expected %b", c, valid_out, c == 4);
        end
      end
      if (c == 6) begin
        checks++;
        if (read0 !== 1'b1) begin
          errors++;
          $display("FAIL pause_resume: got read0=%b expected 1", read0);
        end
      end
    end
    wait_drain("pause");
  endtask

  task automatic test_bubble();
    do_reset();
    load(1'b0, 2);
    load(1'b1, 3);
    expect_word(1'b0, 0, 1);
    expect_word(1'b1, 0, 2);
    for (int c = 1; c <= 4; c++) begin
      logic [1:0] want;
      @(negedge clk);
      #1;
      want = (c <= 2) ? 2'b01 : (c == 3) ? 2'b00 : 2'b10;
      checks++;
      if ({read1, read0} !== want) begin
        errors++;
        $display("FAIL bubble_c%0d: got read1/read0=%b expected %b", c, {read1, read0}, want);
      end
    end
    wait_drain("bubble");
  endtask

  task automatic test_reset_midflight();
    int seen;
    do_reset();
    load(1'b0, 4);
    expect_word(1'b0, 0, 3);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    q0.delete();
    exp_q.delete();
    fifo0_empty = 1'b1;
    #1;
    checks++;
    if ({valid_out, class_out, data_out, cnt0, cnt1, read0, read1} !== '0) begin
      errors++;
      $display("FAIL midflight_reset: valid=%b data=%0h cnt0=%0d rd=%b%b expected all 0",
               valid_out, data_out, cnt0, read0, read1);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      if (valid_out) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midflight_ghost: got %0d valid cycles expected 0", seen);
    end
    load(1'b0, 1);
    expect_word(1'b0, 0, 0);
    wait_drain("midflight");
    checks++;
    if (cnt0 !== 8'd1) begin
      errors++;
      $display("FAIL midflight_cnt: got cnt0=%0d expected 1", cnt0);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    load(1'b0, 256);
    expect_word(1'b0, 0, 255);
    wait_drain("wrap");
    checks++;
    if (cnt0 !== 8'd0 || cnt1 !== 8'd0) begin
      errors++;
      $display("FAIL wrap_cnt: got cnt0=%0d cnt1=%0d expected 0 0", cnt0, cnt1);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_class1_only();
    test_pause();
    test_bubble();
    test_reset_midflight();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/class_arbiter.md
CLASS_ARBITER -- requirements
Module: class_arbiter

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 10, width of each data word; bit DATA_SIZE-1 is the class bit.
REQ-002 SHALL have parameter WEIGHT0, default 3, pop credit per turn for class 0; legal range 1..15.
REQ-003 SHALL have parameter WEIGHT1, default 1, pop credit per turn for class 1; legal range 1..15.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 fifo0_data  input  DATA_SIZE  class-0 FIFO pop data, valid the cycle after read0.
REQ-007 fifo0_empty  input  1  class-0 FIFO empty flag.
REQ-008 fifo1_data  input  DATA_SIZE  class-1 FIFO pop data, valid the cycle after read1.
REQ-009 fifo1_empty  input  1  class-1 FIFO empty flag.
REQ-010 dest_pause  input  1  downstream backpressure; high blocks new pops.
REQ-011 read0  output  1  pop strobe to class-0 FIFO, combinational from registered state and inputs.
REQ-012 read1  output  1  pop strobe to class-1 FIFO, combinational from registered state and inputs.
REQ-013 data_out  output  DATA_SIZE  registered forwarded word.
REQ-014 valid_out  output  1  registered; data_out valid this cycle.
REQ-015 class_out  output  1  registered; class of data_out (0 or 1).
REQ-016 cnt0  output  8  registered count of class-0 words delivered, wraps 255->0.
REQ-017 cnt1  output  8  registered count of class-1 words delivered, wraps 255->0.

Function
REQ-018 FSM states: IDLE, SERVE0, SERVE1; plus 4-bit credit counter, last-served bit, one-deep in-flight register (rd_vld, rd_cls).
REQ-019 read0 = (state==SERVE0) & ~fifo0_empty & ~dest_pause; read1 likewise for SERVE1/fifo1; never both high; never asserted while the target FIFO is empty.
REQ-020 Each read decrements credit by 1.
REQ-021 IDLE: if either FIFO non-empty, next state serves the class opposite last-served if non-empty, else the non-empty one; credit loads that class's weight; no read in IDLE.
REQ-022 SERVEk, read with credit==1: if other FIFO non-empty, next state SERVE(other), credit=WEIGHT(other); else stay SERVEk, credit=WEIGHTk.
REQ-023 SERVEk, FIFO k empty and not paused: other non-empty -> SERVE(other) with its weight (one bubble cycle); both empty -> IDLE.
REQ-024 dest_pause high: state, credit and last-served held; no reads issued.
REQ-025 last-served updates to k on every readk.
REQ-026 In-flight: rd_vld<=readk|..., rd_cls<=k at edge of read cycle N; at edge ending N+1, data_out<=fifo_k_data, class_out<=k, valid_out<=1; valid_out=0 otherwise. Read-to-valid latency: 2 cycles.
REQ-027 Word already popped when dest_pause rises SHALL still be delivered (at most one word after pause).
REQ-028 cnt0/cnt1 increment on the edge that sets valid_out for that class.
REQ-029 Sustained throughput: one word per cycle while the granted FIFO is non-empty and not paused.

Reset
REQ-030 reset low asynchronously forces: state=IDLE, credit=0, last-served=1, rd_vld=0, data_out=0, valid_out=0, class_out=0, cnt0=cnt1=0; read0/read1 therefore 0.
REQ-031 Reset mid-transfer SHALL discard the in-flight word; no valid_out for it after release.

Verification
REQ-032 Both FIFOs hold 8 words, no pause, defaults -> pop order 0,0,0,1,0,0,0,1..., valid_out continuous after 2-cycle startup, cnt0=6,cnt1=2 after 8 words.
REQ-033 Only class-1 holds 4 words -> four consecutive read1, credit reloads each time, then IDLE; cnt1=4.
REQ-034 dest_pause high 3 cycles mid-stream -> reads stop that cycle, exactly one in-flight word delivered, credit resumes unchanged.
REQ-035 Class-0 empties after 2 of 3 credits with class-1 non-empty -> one bubble, then SERVE1 with credit 1.
REQ-036 Assert reset while rd_vld=1 -> all outputs 0 immediately; after release no valid_out until a new read.
REQ-037 Deliver 256 class-0 words -> cnt0 wraps to 0; read0 never high while fifo0_empty=1 (assertion).
